dmem_responder: RTL

//  Data-memory responder: the slave end of the MEM-stage data-memory request interface.
//  - Accepts one load/store request at a time (address, write data, byte enables).
//  - Holds the request for a programmable number of wait states.
//  - Performs a byte-masked access to an internal word array.
//  - Returns the read word through a valid/ready response channel.
//  - The LSU in the MEM stage is the initiator; it does sign/zero extension of returned words.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_responder_if.sv | 38 +++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 102 ++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Used by dmem_responder and its testbench.
package dmem_pkg;

  localparam int unsigned DMEM_LAT_W = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;

  // Out-of-range index bits, or a full-word / low-halfword store whose lanes do not fit the address.
  function automatic logic dmem_bad_req(dmem_req_t req, int unsigned aw);
    logic bad;
    bad = (req.addr >> (aw + 2)) != 32'd0;
    if (req.we && req.be == 4'hf && req.addr[1:0] != 2'b00) bad = 1'b1;
    if (req.we && req.be == 4'h3 && req.addr[1]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory request/response channel; the LSU is master, the responder slave.
// rsp_err exists only when DMEM_ERR_EN is defined.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
`ifdef DMEM_ERR_EN
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
`endif

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
// Contents are not reset.
module dmem_array #(
  parameter  int unsigned DEPTH = 1024,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits LATENCY cycles, accesses the array, responds.
// Optional macro DMEM_ERR_EN adds range/alignment checking reported on rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [DMEM_LAT_W-1:0] LAT = DMEM_LAT_W'(LATENCY);

  dmem_state_t           state_q, state_d;
  logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
  dmem_req_t             req_q, req_d;
  dmem_rsp_t             rsp;
  logic                  req_err;
  logic                  mem_en;
  logic [31:0]           mem_rdata;

`ifdef DMEM_ERR_EN
  assign req_err     = dmem_bad_req(req_q, AW);
  assign bus.rsp_err = rsp.err;
`else
  // Upper address bits alias and the byte offset is the LSU's concern.
  logic unused_bits;
  assign req_err     = 1'b0;
  assign unused_bits = ^{req_q.addr[31:AW+2], req_q.addr[1:0], rsp.err};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    mem_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d   = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};
          cnt_d   = LAT;
          state_d = (LATENCY == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DMEM_LAT_W'(1)) state_d = ACCESS;
      end
      ACCESS: begin
        // A reset landing on the access edge must not commit the store.
        mem_en  = ~rst & ~req_err;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The RAM read register holds stale data after stores and errors, so gate it here.
  always_comb begin
    rsp.rdata = '0;
    rsp.err   = 1'b0;
    if (state_q == RESP) begin
      rsp.err = req_err;
      if (!req_q.we && !req_err) rsp.rdata = mem_rdata;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp.rdata;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk    (clk),
    .en_i   (mem_en),
    .we_i   (req_q.we),
    .addr_i (req_q.addr[AW+1:2]),
    .wdata_i(req_q.wdata),
    .be_i   (req_q.be),
    .rdata_o(mem_rdata)
  );

endmodule
